// File: rtl/gap_pool_unit.sv
// Global average pooling over a channel-interleaved ReLU stream: one signed sum per
// channel, averaged by an arithmetic shift, then exposed through a registered read port.

module gap_pool_lane #(
  parameter int DATA_W       = 16,
  parameter int SPATIAL_LOG2 = 6,
  parameter int ACC_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic              wr,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result
);
  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= acc + {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
      // (acc >>> SPATIAL_LOG2) truncated to DATA_W bits is exactly this slice
      if (wr) result <= acc[SPATIAL_LOG2 +: DATA_W];
    end
  end
endmodule

module gap_pool_unit #(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 8,
  parameter int SPATIAL_LOG2 = 6,
  parameter int ACC_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gap_en,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      gap_done,
  input  logic [$clog2(NUM_CH)-1:0] rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                debug_state
);
  localparam int              CH_W    = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DIVIDE = 2'd2, DONE = 2'd3} state_t;

  state_t                        state;
  logic [CH_W-1:0]               ch_cnt;
  logic [SPATIAL_LOG2-1:0]       pix_cnt;
  logic                          accept;
  logic                          clr;
  logic                          last_ch;
  logic [NUM_CH-1:0]             add;
  logic [NUM_CH-1:0]             wr;
  logic [NUM_CH-1:0][DATA_W-1:0] results;

  assign accept      = (state == ACCUM) && in_valid && gap_en;
  assign clr         = (state == IDLE) && gap_en;
  assign last_ch     = (ch_cnt == LAST_CH);
  assign in_ready    = (state == ACCUM);
  assign debug_state = state;

  // ch_cnt selects the lane both for accumulation and for the DIVIDE sweep
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign add[c] = accept && (ch_cnt == CH_W'(c));
    assign wr[c]  = (state == DIVIDE) && (ch_cnt == CH_W'(c));

    gap_pool_lane #(
      .DATA_W      (DATA_W),
      .SPATIAL_LOG2(SPATIAL_LOG2),
      .ACC_W       (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .add   (add[c]),
      .wr    (wr[c]),
      .sample(in_data),
      .result(results[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      gap_done <= 1'b0;
    end else begin
      gap_done <= 1'b0;
      case (state)
        IDLE: if (gap_en) begin
          ch_cnt  <= '0;
          pix_cnt <= '0;
          state   <= ACCUM;
        end
        ACCUM: if (accept) begin
          ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
          if (last_ch) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (&pix_cnt) state <= DIVIDE;
          end
        end
        DIVIDE: begin
          ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
          if (last_ch) begin
            state    <= DONE;
            gap_done <= 1'b1;
          end
        end
        DONE: if (!gap_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          rd_data <= '0;
    else if (32'(rd_addr) < NUM_CH)   rd_data <= results[rd_addr];
    else                              rd_data <= '0;
  end
endmodule

// File: tb/tb_gap_pool_unit.sv
// Scoreboard bench for gap_pool_unit: stimulus pushes expected reads and done
// latencies; a negedge monitor pops and compares as the DUT presents them.
module tb_gap_pool_unit;
  localparam int DATA_W = 16, NUM_CH = 4, SPATIAL_LOG2 = 2, ACC_W = 32;
  localparam int NSMP = NUM_CH << SPATIAL_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gap_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  rd_addr = '0;
  logic        in_ready, gap_done;
  logic [15:0] rd_data;
  logic [1:0]  debug_state;

  gap_pool_unit #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SPATIAL_LOG2(SPATIAL_LOG2), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .gap_en(gap_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .gap_done(gap_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0, tot_cnt = 0;
  logic [15:0] exp_rd[$];
  int          exp_done[$];
  logic        rd_req = 1'b0, rd_pend = 1'b0;
  int          cyc = 0, last_acc = 0, acc_cnt = 0;
  logic [15:0] frm [NSMP];
  logic [15:0] old [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tot_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  // Monitor: tracks accepts, compares registered reads and gap_done latency
  always @(negedge clk) begin
    logic [15:0] e;
    int lat;
    if (!rst && in_valid && in_ready && gap_en) begin
      last_acc = cyc + 1;
      acc_cnt++;
    end
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        tot_cnt++;
        $display("FAIL rd_unexpected: got %0h with no expectation", rd_data);
      end else begin
        e = exp_rd.pop_front();
        check("rd_data", 32'(rd_data), 32'(e));
      end
    end
    if (gap_done) begin
      if (exp_done.size() == 0) begin
        tot_cnt++;
        $display("FAIL gap_done_spurious: got pulse at cycle %0d, want none", cyc);
      end else begin
        lat = cyc + 1 - last_acc;
        check("gap_done_latency", 32'(lat), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] want);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_rd.push_back(want);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_all(input logic [15:0] e0, e1, e2, e3);
    rd(2'd0, e0); rd(2'd1, e1); rd(2'd2, e2); rd(2'd3, e3);
  endtask

  task automatic set_const(input logic [15:0] v0, v1, v2, v3);
    for (int i = 0; i < NSMP; i++)
      case (i % NUM_CH)
        0: frm[i] = v0;
        1: frm[i] = v1;
        2: frm[i] = v2;
        default: frm[i] = v3;
      endcase
  endtask

  task automatic send_frame(input int pause_at, input bit junk_after, input bit push_done,
                            input bit rd_old);
    gap_en = 1'b1; in_valid = 1'b0;
    tick();
    check("in_ready_accum", 32'(in_ready), 32'd1);
    check("state_accum", 32'(debug_state), 32'd1);
    for (int i = 0; i < NSMP; i++) begin
      if (i == pause_at) begin
        rd_req = 1'b0; gap_en = 1'b0; in_data = 16'h1234;
        for (int p = 0; p < 7; p++) begin
          in_valid = 1'($urandom_range(0, 1));
          tick();
        end
        gap_en = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = frm[i];
      if (rd_old) begin
        rd_addr = 2'(i % NUM_CH);
        rd_req  = 1'b1;
        exp_rd.push_back(old[i % NUM_CH]);
      end
      if (push_done && i == NSMP - 1) exp_done.push_back(NUM_CH + 1);
      tick();
    end
    rd_req = 1'b0;
    if (junk_after) begin in_valid = 1'b1; in_data = 16'h7777; end
    else in_valid = 1'b0;
    check("state_divide", 32'(debug_state), 32'd2);
    check("in_ready_divide", 32'(in_ready), 32'd0);
  endtask

  task automatic finish_frame();
    repeat (6) tick();
    in_valid = 1'b0;
    check("state_done", 32'(debug_state), 32'd3);
    gap_en = 1'b0;
    tick();
    check("state_idle", 32'(debug_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset defaults
    repeat (3) tick();
    rst = 1'b0;
    check("rst_state", 32'(debug_state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_gap_done", 32'(gap_done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rd_all(16'd0, 16'd0, 16'd0, 16'd0);

    // Basic average
    set_const(16'd10, 16'd20, 16'd30, 16'd40);
    send_frame(-1, 1'b0, 1'b1, 1'b0);
    finish_frame();
    rd_all(16'd10, 16'd20, 16'd30, 16'd40);

    // Negative rounding and extremes
    for (int p = 0; p < 4; p++) begin
      frm[p*4+0] = (p == 0) ? 16'hFFFF : 16'h0000;
      frm[p*4+1] = 16'h8000;
      frm[p*4+2] = 16'h7FFF;
      frm[p*4+3] = (p < 3) ? 16'h0001 : 16'h0000;
    end
    send_frame(-1, 1'b0, 1'b1, 1'b0);
    finish_frame();
    rd_all(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000);

    // Pause mid-frame plus junk input during DIVIDE/DONE
    set_const(16'd10, 16'd20, 16'd30, 16'd40);
    send_frame(6, 1'b1, 1'b1, 1'b0);
    finish_frame();
    rd_all(16'd10, 16'd20, 16'd30, 16'd40);

    // Reset two cycles into DIVIDE
    send_frame(-1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    gap_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_div_state", 32'(debug_state), 32'd0);
    check("rst_div_gap_done", 32'(gap_done), 32'd0);
    repeat (6) tick();
    rd_all(16'd0, 16'd0, 16'd0, 16'd0);
    set_const(16'd5, 16'd6, 16'd7, 16'd8);
    send_frame(-1, 1'b0, 1'b1, 1'b0);
    finish_frame();
    rd_all(16'd5, 16'd6, 16'd7, 16'd8);

    // Back-to-back: gap_en held through DONE, then a one-cycle drop
    set_const(16'd10, 16'd20, 16'd30, 16'd40);
    send_frame(-1, 1'b0, 1'b1, 1'b0);
    repeat (12) tick();
    check("hold_state_done", 32'(debug_state), 32'd3);
    check("hold_gap_done_low", 32'(gap_done), 32'd0);
    gap_en = 1'b0;
    tick();
    check("b2b_state_idle", 32'(debug_state), 32'd0);
    old[0] = 16'd10; old[1] = 16'd20; old[2] = 16'd30; old[3] = 16'd40;
    set_const(16'd1, 16'd2, 16'd3, 16'd4);
    send_frame(-1, 1'b0, 1'b1, 1'b1);
    rd(2'd0, 16'd10);  // same edge as the channel-0 write: old value
    rd(2'd0, 16'd1);
    finish_frame();
    rd_all(16'd1, 16'd2, 16'd3, 16'd4);

    repeat (3) tick();
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("accepted_samples", 32'(acc_cnt), 32'(7 * NSMP));
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
